// File: rtl/pattern_detector_pkg.sv
// Shared types and defaults for the N-bit serial pattern detector.
// The one-hot state encoding keeps the y decode to a single flop bit.
package pattern_detector_pkg;

  typedef enum logic [3:0] {
    EMPTY   = 4'b0001,
    FILLING = 4'b0010,
    ARMED   = 4'b0100,
    MATCH   = 4'b1000
  } state_t;

  localparam int DEFAULT_N     = 4;
  localparam int DEFAULT_CNT_W = 8;

endpackage

// File: rtl/pattern_detector_n_if.sv
// Serial data, configuration and match-status bundle for pattern_detector_n.
interface pattern_detector_n_if
  import pattern_detector_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int CNT_W = DEFAULT_CNT_W
);
  localparam int FILL_W = $clog2(N + 1);

  logic              x;
  logic              x_valid;
  logic [N-1:0]      cfg_pattern;
  logic              cfg_overlap;
  logic              cfg_load;
  logic              y;
  logic [CNT_W-1:0]  match_count;
  logic [FILL_W-1:0] fill;

  modport master (
    output x, x_valid, cfg_pattern, cfg_overlap, cfg_load,
    input  y, match_count, fill
  );

  modport slave (
    input  x, x_valid, cfg_pattern, cfg_overlap, cfg_load,
    output y, match_count, fill
  );

endinterface

// File: rtl/pattern_detector_n_sat_counter.sv
// Up-counter that sticks at its all-ones value; clr and rst both zero it.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pattern_detector_n.sv
// Moore detector for a runtime-loaded N-bit pattern on a qualified serial stream,
// with overlap/non-overlap history handling and a saturating match counter.
module pattern_detector_n
  import pattern_detector_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  pattern_detector_n_if.slave bus
);

  localparam int                FILL_W = $clog2(N + 1);
  localparam logic [FILL_W-1:0] FULL   = FILL_W'(N);

  state_t            state_q, state_n;
  logic [N-1:0]      pat_q;
  logic              ovl_q;
  logic [N-1:0]      hist_q;
  logic [FILL_W-1:0] fill_q;

  logic              accept;
  logic              hit;
  logic [N-1:0]      hist_shift;
  logic [FILL_W-1:0] fill_inc;

  // A sample arriving together with cfg_load is dropped, so it never counts as accepted.
  always_comb begin
    accept     = bus.x_valid && !bus.cfg_load;
    hist_shift = N'({hist_q, bus.x});
    fill_inc   = (fill_q == FULL) ? FULL : fill_q + 1'b1;
    hit        = accept && (fill_inc == FULL) && (hist_shift == pat_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= '0;
      ovl_q  <= 1'b1;
      hist_q <= '0;
      fill_q <= '0;
    end else if (bus.cfg_load) begin
      pat_q  <= bus.cfg_pattern;
      ovl_q  <= bus.cfg_overlap;
      hist_q <= '0;
      fill_q <= '0;
    end else if (accept) begin
      // Non-overlap mode forgets everything once a match is consumed.
      hist_q <= (hit && !ovl_q) ? '0 : hist_shift;
      fill_q <= (hit && !ovl_q) ? '0 : fill_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    if (bus.cfg_load) begin
      state_n = EMPTY;
    end else if (hit) begin
      state_n = MATCH;
    end else if (accept) begin
      state_n = (fill_inc == FULL) ? ARMED : FILLING;
    end else if (state_q == MATCH) begin
      state_n = ovl_q ? ARMED : EMPTY;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .clr (bus.cfg_load),
    .inc (hit),
    .q   (bus.match_count)
  );

  assign bus.y    = (state_q == MATCH);
  assign bus.fill = fill_q;

endmodule

// File: doc/pattern_detector_n.md
# pattern_detector_n

Parametrised Moore sequence detector for a serial bit stream. It generalises the team's fixed four-state detector to an N-bit runtime-loadable pattern. It adds a valid qualifier, overlap/non-overlap mode and a saturating match counter. It sits on any serial decode path that needs a registered, glitch-free match flag.

## Interface
- N, default 4: pattern length in bits, legal range 2..16.
- CNT_W, default 8: match counter width.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- x  in  1  serial data bit.
- x_valid  in  1  x is sampled only when high.
- cfg_pattern  in  N  pattern; bit N-1 is the first bit received.
- cfg_overlap  in  1  1 = overlapping matches allowed, 0 = history discarded after a match.
- cfg_load  in  1  captures cfg_pattern/cfg_overlap and clears history and counter.
- y  out  1  Moore match flag.
- match_count  out  CNT_W  saturating number of matches since reset/load.
- fill  out  $clog2(N+1)  valid history bits held, saturating at N.

## Operation
- Internal registers:
  - pat_q[N-1:0], ovl_q: captured configuration.
  - hist[N-1:0]: shift register.
  - fill.
  - state.
- Accepted sample when x_valid=1: hist_n = {hist[N-2:0], x}; fill_n = min(fill+1, N).
- hit = accepted sample && fill_n==N && hist_n==pat_q.
- On hit:
  - match_count increments, saturating at 2^CNT_W-1.
  - If ovl_q=0: hist<=0 and fill<=0.
  - If ovl_q=1: hist<=hist_n and fill stays N.
- FSM states:
  - EMPTY: fill==0.
  - FILLING: 0<fill<N.
  - ARMED: fill==N, no hit.
  - MATCH: y=1.
- y = (state==MATCH); no other state drives y high.
- FSM transitions:
  - Any state, hit → MATCH.
  - Accepted sample without hit → FILLING if fill_n<N, else ARMED.
  - No accepted sample: MATCH → ARMED if ovl_q=1, EMPTY if ovl_q=0; all other states hold.
- Priority: rst > cfg_load > x_valid. A sample presented in the same cycle as cfg_load is dropped.
- cfg_load: pat_q<=cfg_pattern, ovl_q<=cfg_overlap, hist<=0, fill<=0, match_count<=0, state<=EMPTY.
- Reset values:
  - Outputs: y=0, match_count=0, fill=0.
  - Internal: state=EMPTY, pat_q=0, ovl_q=1, hist=0.
- Boundary conditions:
  - Back-to-back hits in overlap mode (e.g. all-ones pattern) keep y high on consecutive cycles.
  - Saturated counter holds its value; y still pulses.
  - A pattern that arrives before fill reaches N never hits, even if hist happens to equal pat_q.

## Timing
- Sample accepted at edge k → y, match_count and fill reflect it after edge k; latency is one cycle from sample to flag.
- y is high for exactly one cycle per hit unless the next accepted sample also hits.
- Bubbles (x_valid=0) do not disturb hist or fill.
- A bubble in MATCH drops y after one cycle.
- rst or cfg_load asserted in any state: all listed registers take their reset/load values at that edge; y=0 the following cycle.

## Structure
- Shared package pattern_detector_pkg holds:
  - state_t typedef, one-hot encoded: EMPTY=4'b0001, FILLING=4'b0010, ARMED=4'b0100, MATCH=4'b1000.
  - Default N / CNT_W constants.
- Next-state and output logic live in the block, with a registered state and a purely state-decoded output.
- One sub-module: sat_counter (params W; inputs clk, rst, clr, inc; output q), used for match_count.

## Test plan
- Basic match:
  - Stimulus: N=4, load 4'b1011, overlap=1; stream 1,0,1,1 with x_valid=1.
  - Required: y=1 only in the cycle after the 4th bit; match_count=1; fill=4.
- Overlap mode:
  - Stimulus: overlap=1; stream 1011011.
  - Required: hits after bits 4 and 7; match_count=2.
- Non-overlap mode:
  - Stimulus: same stream with overlap=0.
  - Required: one hit after bit 4; fill returns to 0 then reaches 3; match_count=1.
- Bubbles:
  - Stimulus: 1,0,1,1 with x_valid=0 for 2 cycles between every bit.
  - Required: y=0 during the bubbles; single hit one cycle after the last valid bit.
- Load mid-stream:
  - Stimulus: after 1,0,1 accepted, pulse cfg_load (same pattern) with x=1, x_valid=1 in that cycle, then one more valid 1.
  - Required: fill=0 after the load edge, fill=1 after the next; no hit; match_count=0.
- Saturation and reset:
  - Stimulus: CNT_W=2, pattern 4'b1111, overlap=1; 8 valid ones.
  - Required: y high 5 consecutive cycles; match_count saturates at 3.
  - Then: rst while in MATCH → y=0, match_count=0, fill=0, pat_q=0 after that edge.
